// File: rtl/bsg_vanilla_pkg.sv
// Shared FP datapath types for the vanilla core: recoded-float widths, fflags
// bit positions and the fdiv/fsqrt writeback buffer entry.
package bsg_vanilla_pkg;

  localparam int fpu_recoded_exp_width_gp  = 8;
  localparam int fpu_recoded_sig_width_gp  = 24;
  localparam int fpu_recoded_data_width_gp = fpu_recoded_exp_width_gp + fpu_recoded_sig_width_gp + 1;
  localparam int RV32_reg_addr_width_gp    = 5;
  localparam int fflags_width_gp           = 5;

  // Positions inside the {NV,DZ,OF,UF,NX} exception flag vector.
  localparam int fflags_nv_bit_gp = 4;
  localparam int fflags_dz_bit_gp = 3;
  localparam int fflags_of_bit_gp = 2;
  localparam int fflags_uf_bit_gp = 1;
  localparam int fflags_nx_bit_gp = 0;

  typedef struct packed {
    logic [RV32_reg_addr_width_gp-1:0]    rd;
    logic [fpu_recoded_data_width_gp-1:0] data;
    logic [fflags_width_gp-1:0]           fflags;
  } fdiv_wb_entry_s;

endpackage

// File: rtl/fpu_fdiv_wb_fifo.sv
// Circular buffer of completed fdiv/fsqrt results awaiting the FP regfile
// write port. Full/empty come from read/write pointers carrying an extra wrap bit.
module fpu_fdiv_wb_fifo
  import bsg_vanilla_pkg::*;
#(
  parameter int els_p = 2
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  input  logic           push_i,
  input  fdiv_wb_entry_s data_i,
  input  logic           pop_i,
  output fdiv_wb_entry_s data_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int ptr_w_lp = $clog2(els_p);

  logic [ptr_w_lp:0] wptr_q, wptr_d;
  logic [ptr_w_lp:0] rptr_q, rptr_d;
  fdiv_wb_entry_s    mem_q [els_p];
  fdiv_wb_entry_s    mem_d [els_p];
  logic              do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp])
                 && (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);
  assign data_o  = mem_q[rptr_q[ptr_w_lp-1:0]];

  always_comb begin
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wptr_d  = wptr_q + {{ptr_w_lp{1'b0}}, do_push};
    rptr_d  = rptr_q + {{ptr_w_lp{1'b0}}, do_pop};
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wptr_q[ptr_w_lp-1:0]] = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fpu_fdiv_fsqrt_wb.sv
// Writeback stage for fdiv/fsqrt results: buffers them, yields the FP regfile
// port to the FMA pipeline, and keeps a pending-rd scoreboard. Optional
// same-cycle bypass of an empty buffer is enabled by FPU_FDIV_WB_BYPASS_EN.
module fpu_fdiv_fsqrt_wb
  import bsg_vanilla_pkg::*;
#(
  parameter int exp_width_p      = 8,
  parameter int sig_width_p      = 24,
  parameter int reg_addr_width_p = 5,
  parameter int els_p            = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               issue_v_i,
  input  logic [reg_addr_width_p-1:0]        issue_rd_i,
  input  logic                               fdiv_v_i,
  input  logic [reg_addr_width_p-1:0]        fdiv_rd_i,
  input  logic [exp_width_p+sig_width_p:0]   fdiv_result_i,
  input  logic [4:0]                         fdiv_fflags_i,
  output logic                               fdiv_yumi_o,
  input  logic                               fpu_wb_busy_i,
  output logic                               wb_v_o,
  output logic [reg_addr_width_p-1:0]        wb_rd_o,
  output logic [exp_width_p+sig_width_p:0]   wb_data_o,
  output logic [4:0]                         wb_fflags_o,
  output logic [2**reg_addr_width_p-1:0]     pending_o,
  output logic                               idle_o
);

  fdiv_wb_entry_s in_entry, head_entry, wb_entry;
  logic           full, empty, push, pop;
  logic [2**reg_addr_width_p-1:0] pending_q, pending_d;

  assign in_entry = '{rd: fdiv_rd_i, data: fdiv_result_i, fflags: fdiv_fflags_i};

  fpu_fdiv_wb_fifo #(.els_p(els_p)) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .data_i    (in_entry),
    .pop_i     (pop),
    .data_o    (head_entry),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Outputs are forced low while in reset so a discarded entry never writes back.
  always_comb begin
    fdiv_yumi_o = reset_n_i & fdiv_v_i & ~full;
`ifdef FPU_FDIV_WB_BYPASS_EN
    wb_v_o   = reset_n_i & ~fpu_wb_busy_i & (~empty | fdiv_v_i);
    wb_entry = empty ? in_entry : head_entry;
    push     = fdiv_yumi_o & ~(empty & ~fpu_wb_busy_i);
`else
    wb_v_o   = reset_n_i & ~fpu_wb_busy_i & ~empty;
    wb_entry = head_entry;
    push     = fdiv_yumi_o;
`endif
    pop         = wb_v_o & ~empty;
    wb_rd_o     = wb_v_o ? wb_entry.rd     : '0;
    wb_data_o   = wb_v_o ? wb_entry.data   : '0;
    wb_fflags_o = wb_v_o ? wb_entry.fflags : '0;
  end

  // Clear before set so a same-cycle re-issue of the written rd stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_v_o) begin
      pending_d[wb_entry.rd] = 1'b0;
    end
    if (issue_v_i) begin
      pending_d[issue_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign idle_o    = empty & ~|pending_q;

  issue_to_pending_rd: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    issue_v_i |-> (!pending_q[issue_rd_i] || (wb_v_o && (wb_rd_o == issue_rd_i))));

endmodule

// File: tb/tb_fpu_fdiv_fsqrt_wb.sv
// Directed bench for fpu_fdiv_fsqrt_wb in its default (registered) build:
// per-cycle vector table plus hand-written reset sequences.
module tb_fpu_fdiv_fsqrt_wb;

  logic        clk;
  logic        reset_n;
  logic        issue_v;
  logic [4:0]  issue_rd;
  logic        fdiv_v;
  logic [4:0]  fdiv_rd;
  logic [32:0] fdiv_result;
  logic [4:0]  fdiv_fflags;
  logic        fdiv_yumi;
  logic        busy;
  logic        wb_v;
  logic [4:0]  wb_rd;
  logic [32:0] wb_data;
  logic [4:0]  wb_fflags;
  logic [31:0] pending;
  logic        idle;

  int checks = 0;
  int errors = 0;

  fpu_fdiv_fsqrt_wb dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .issue_v_i     (issue_v),
    .issue_rd_i    (issue_rd),
    .fdiv_v_i      (fdiv_v),
    .fdiv_rd_i     (fdiv_rd),
    .fdiv_result_i (fdiv_result),
    .fdiv_fflags_i (fdiv_fflags),
    .fdiv_yumi_o   (fdiv_yumi),
    .fpu_wb_busy_i (busy),
    .wb_v_o        (wb_v),
    .wb_rd_o       (wb_rd),
    .wb_data_o     (wb_data),
    .wb_fflags_o   (wb_fflags),
    .pending_o     (pending),
    .idle_o        (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        fv;
    logic [4:0]  frd;
    logic [32:0] fdata;
    logic [4:0]  fff;
    logic        busy;
    logic        e_yumi;
    logic        e_wbv;
    logic [4:0]  e_rd;
    logic [32:0] e_data;
    logic [4:0]  e_ff;
    logic [31:0] e_pend;
    logic        e_idle;
  } vec_t;

  vec_t vecs[$];

  localparam logic [32:0] D15 = 33'h080400000;  // recoded 1.5
  localparam logic [32:0] DA  = 33'h012345678;
  localparam logic [32:0] DB  = 33'h0aaaa5555;
  localparam logic [32:0] DC  = 33'h155550001;
  localparam logic [32:0] DD  = 33'h0deadbeef;
  localparam logic [32:0] DE  = 33'h100000001;
  localparam logic [32:0] DF  = 33'h0cafef00d;
  localparam logic [32:0] DG  = 33'h1ff800000;
  localparam logic [32:0] DH  = 33'h013579bdf;
  localparam logic [32:0] DI  = 33'h0fedcba98;

  task automatic add(input logic iv, input logic [4:0] ird, input logic fv,
                     input logic [4:0] frd, input logic [32:0] fdata,
                     input logic [4:0] fff, input logic bsy, input logic ey,
                     input logic ewv, input logic [4:0] erd, input logic [32:0] edata,
                     input logic [4:0] eff, input logic [31:0] epend, input logic eidle);
    vec_t v;
    v.iv = iv; v.ird = ird; v.fv = fv; v.frd = frd; v.fdata = fdata; v.fff = fff;
    v.busy = bsy; v.e_yumi = ey; v.e_wbv = ewv; v.e_rd = erd; v.e_data = edata;
    v.e_ff = eff; v.e_pend = epend; v.e_idle = eidle;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int cyc, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird, input logic fv,
                       input logic [4:0] frd, input logic [32:0] fdata,
                       input logic [4:0] fff, input logic bsy);
    issue_v = iv; issue_rd = ird; fdiv_v = fv; fdiv_rd = frd;
    fdiv_result = fdata; fdiv_fflags = fff; busy = bsy;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 1'b1, 5'd3, D15, 5'd0, 1'b0);

    // Reset held 3 cycles with a result offered.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_yumi", i, 64'(fdiv_yumi), 64'd0);
      chk("rst_wbv",  i, 64'(wb_v),      64'd0);
      chk("rst_pend", i, 64'(pending),   64'd0);
      chk("rst_idle", i, 64'(idle),      64'd1);
    end

    // Single op, recoded 1.5 to rd3
    add(1,3, 0,0,0,0, 0,   0,0,0,0,0,      32'h0,   1);
    add(0,0, 1,3,D15,0, 0, 1,0,0,0,0,      32'h8,   0);
    add(0,0, 0,0,0,0, 0,   0,1,3,D15,0,    32'h8,   0);
    add(0,0, 0,0,0,0, 0,   0,0,0,0,0,      32'h0,   1);
    // Busy stall: 4 busy cycles with one buffered result
    add(1,6, 0,0,0,0, 1,   0,0,0,0,0,      32'h0,   1);
    add(0,0, 1,6,DA,5'b00001, 1, 1,0,0,0,0, 32'h40, 0);
    for (int i = 0; i < 4; i++) add(0,0, 0,0,0,0, 1, 0,0,0,0,0, 32'h40, 0);
    add(0,0, 0,0,0,0, 0,   0,1,6,DA,5'b00001, 32'h40, 0);
    add(0,0, 0,0,0,0, 0,   0,0,0,0,0,      32'h0,   1);
    // Full buffer: rd1, rd2 buffered under busy, rd4 refused until a slot frees
    add(1,1, 0,0,0,0, 1,   0,0,0,0,0,      32'h0,   1);
    add(1,2, 1,1,DB,0, 1,  1,0,0,0,0,      32'h2,   0);
    add(1,4, 1,2,DC,0, 1,  1,0,0,0,0,      32'h6,   0);
    add(0,0, 1,4,DD,0, 1,  0,0,0,0,0,      32'h16,  0);
    add(0,0, 1,4,DD,0, 0,  0,1,1,DB,0,     32'h16,  0);
    add(0,0, 1,4,DD,0, 0,  1,1,2,DC,0,     32'h14,  0);
    add(0,0, 0,0,0,0, 0,   0,1,4,DD,0,     32'h10,  0);
    add(0,0, 0,0,0,0, 0,   0,0,0,0,0,      32'h0,   1);
    // Scoreboard race on rd5: set wins over clear
    add(1,5, 0,0,0,0, 0,   0,0,0,0,0,      32'h0,   1);
    add(0,0, 1,5,DE,0, 0,  1,0,0,0,0,      32'h20,  0);
    add(1,5, 0,0,0,0, 0,   0,1,5,DE,0,     32'h20,  0);
    add(0,0, 0,0,0,0, 0,   0,0,0,0,0,      32'h20,  0);
    add(0,0, 1,5,DF,5'b00001, 0, 1,0,0,0,0, 32'h20, 0);
    add(0,0, 0,0,0,0, 0,   0,1,5,DF,5'b00001, 32'h20, 0);
    add(0,0, 0,0,0,0, 0,   0,0,0,0,0,      32'h0,   1);
    // DZ flag through to writeback
    add(1,7, 0,0,0,0, 0,   0,0,0,0,0,      32'h0,   1);
    add(0,0, 1,7,DG,5'b01000, 0, 1,0,0,0,0, 32'h80, 0);
    add(0,0, 0,0,0,0, 0,   0,1,7,DG,5'b01000, 32'h80, 0);
    add(0,0, 0,0,0,0, 0,   0,0,0,0,0,      32'h0,   1);
    // Push and pop in one cycle while not full
    add(1,8, 0,0,0,0, 0,   0,0,0,0,0,      32'h0,   1);
    add(1,9, 1,8,DH,0, 0,  1,0,0,0,0,      32'h100, 0);
    add(0,0, 1,9,DI,5'b00011, 0, 1,1,8,DH,0, 32'h300, 0);
    add(0,0, 0,0,0,0, 0,   0,1,9,DI,5'b00011, 32'h200, 0);
    add(0,0, 0,0,0,0, 0,   0,0,0,0,0,      32'h0,   1);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      drive(vecs[i].iv, vecs[i].ird, vecs[i].fv, vecs[i].frd, vecs[i].fdata,
            vecs[i].fff, vecs[i].busy);
      @(negedge clk);
      chk("yumi",   i, 64'(fdiv_yumi), 64'(vecs[i].e_yumi));
      chk("wb_v",   i, 64'(wb_v),      64'(vecs[i].e_wbv));
      chk("wb_rd",  i, 64'(wb_rd),     64'(vecs[i].e_rd));
      chk("wb_data",i, 64'(wb_data),   64'(vecs[i].e_data));
      chk("wb_ff",  i, 64'(wb_fflags), 64'(vecs[i].e_ff));
      chk("pending",i, 64'(pending),   64'(vecs[i].e_pend));
      chk("idle",   i, 64'(idle),      64'(vecs[i].e_idle));
    end

    // Reset mid-run with two results buffered behind a busy FMA
    @(posedge clk); #1; drive(1'b1, 5'd10, 1'b0, 5'd0, 33'd0, 5'd0, 1'b1);
    @(posedge clk); #1; drive(1'b1, 5'd11, 1'b1, 5'd10, DA, 5'd0, 1'b1);
    @(negedge clk);
    chk("mr_yumi0", 0, 64'(fdiv_yumi), 64'd1);
    @(posedge clk); #1; drive(1'b0, 5'd0, 1'b1, 5'd11, DB, 5'd0, 1'b1);
    @(negedge clk);
    chk("mr_yumi1", 1, 64'(fdiv_yumi), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 33'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("mr_wbv_in_rst", 2, 64'(wb_v),    64'd0);
    chk("mr_pend_pre",   2, 64'(pending), 64'h0c00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mr_wbv_after",  3, 64'(wb_v),    64'd0);
    chk("mr_idle_after", 3, 64'(idle),    64'd1);
    chk("mr_pend_after", 3, 64'(pending), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_wbv_later",  4, 64'(wb_v),    64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
